// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding and LCD bus constants for the LCD write path.
package lcd_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_LOCK, WAIT_RELEASE, ACK} state_t;
    localparam logic ADDR     = 1'b0;
    localparam logic DATA     = 1'b1;
    localparam logic LOCKED   = 1'b1;
    localparam logic UNLOCKED = 1'b0;
endpackage

// File: rtl/lcd_write_arbiter_if.sv
// lcd_write_arbiter_if: requester bundle plus LCD controller write channel.
//   master: arbiter side (drives reqAck, wrValid, addrOrData, inBus, errorLed)
//   slave : requesters/controller side (drives reqValid, reqRs, reqData, reqBurst, busLock)
interface lcd_write_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   reqValid;
    logic [NUM_REQ-1:0]   reqRs;
    logic [8*NUM_REQ-1:0] reqData;
    logic [NUM_REQ-1:0]   reqBurst;
    logic [NUM_REQ-1:0]   reqAck;
    logic                 busLock;
    logic                 wrValid;
    logic                 addrOrData;
    logic [7:0]           inBus;
    logic                 errorLed;
    modport master (
        input  reqValid, reqRs, reqData, reqBurst, busLock,
        output reqAck, wrValid, addrOrData, inBus, errorLed
    );
    modport slave (
        output reqValid, reqRs, reqData, reqBurst, busLock,
        input  reqAck, wrValid, addrOrData, inBus, errorLed
    );
endinterface

// File: rtl/lcd_rr_pick.sv
// lcd_rr_pick: combinational round-robin picker.
//   i_req_valid: pending requests; i_last: previous grant
//   o_found: any request pending; o_index: first pending after i_last (wrapping)
module lcd_rr_pick #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] i_last,
    output logic                       o_found,
    output logic [$clog2(NUM_REQ)-1:0] o_index
);
    localparam int GW = $clog2(NUM_REQ);
    int w_last;
    // An unreachable grant value behaves like the last requester.
    assign w_last = (int'(i_last) >= NUM_REQ) ? NUM_REQ - 1 : int'(i_last);
    // Scan farthest-first so the nearest hit after w_last overwrites the rest.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_req_valid[GW'((w_last + k) % NUM_REQ)]) begin
                o_found = 1'b1;
                o_index = GW'((w_last + k) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin sharing of the LCD write channel with burst hold and handshake timeout.
//   clk: system clock; rst: asynchronous active-low reset
//   bus: requester bundle in, write channel out, sticky errorLed out
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 10
) (
    input logic                 clk,
    input logic                 rst,
    lcd_write_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    state_t                 r_state, w_state;
    logic [GW-1:0]          r_grant, w_grant, w_pick, w_sel;
    logic                   r_burst, w_burst, w_found, w_go, w_hold, w_tmo;
    logic [TIMEOUT_W-1:0]   r_timer, w_timer;
    logic                   r_wr, w_wr, r_rs, w_rs, r_err, w_err;
    logic [7:0]             r_bus, w_bus;
    logic [NUM_REQ-1:0]     r_ack, w_ack, w_onehot;
    lcd_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req_valid (bus.reqValid),
        .i_last      (r_grant),
        .o_found     (w_found),
        .o_index     (w_pick)
    );
    assign w_hold   = r_burst && bus.reqValid[r_grant];
    assign w_sel    = w_hold ? r_grant : w_pick;
    assign w_go     = w_hold || w_found;
    assign w_tmo    = r_timer == TMAX;
    assign w_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_burst = r_burst;
        w_timer = r_timer;
        w_wr    = r_wr;
        w_rs    = r_rs;
        w_bus   = r_bus;
        w_ack   = r_ack;
        w_err   = r_err;
        case (r_state)
            IDLE: begin
                w_burst = w_go ? bus.reqBurst[w_sel] : 1'b0;
                if (w_go) begin
                    w_grant = w_sel;
                    w_rs    = bus.reqRs[w_sel];
                    w_bus   = bus.reqData[{w_sel, 3'b000} +: 8];
                    w_wr    = 1'b1;
                    w_timer = '0;
                    w_state = WAIT_LOCK;
                end
            end
            WAIT_LOCK, WAIT_RELEASE: begin
                w_timer = r_timer + 1'b1;
                // A stuck controller still frees the requester through ACK.
                if (w_tmo) begin
                    w_err   = 1'b1;
                    w_wr    = 1'b0;
                    w_burst = 1'b0;
                    w_ack   = w_onehot;
                    w_state = ACK;
                end else if (r_state == WAIT_LOCK && bus.busLock == LOCKED) begin
                    w_wr    = 1'b0;
                    w_timer = '0;
                    w_state = WAIT_RELEASE;
                end else if (r_state == WAIT_RELEASE && bus.busLock == UNLOCKED) begin
                    w_ack   = w_onehot;
                    w_state = ACK;
                end
            end
            default: begin
                w_ack   = '0;
                w_state = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= GW'(NUM_REQ - 1);
            r_burst <= 1'b0;
            r_timer <= '0;
            r_wr    <= 1'b0;
            r_rs    <= ADDR;
            r_bus   <= 8'h00;
            r_ack   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_burst <= w_burst;
            r_timer <= w_timer;
            r_wr    <= w_wr;
            r_rs    <= w_rs;
            r_bus   <= w_bus;
            r_ack   <= w_ack;
            r_err   <= w_err;
        end
    end
    assign bus.wrValid    = r_wr;
    assign bus.addrOrData = r_rs;
    assign bus.inBus      = r_bus;
    assign bus.reqAck     = r_ack;
    assign bus.errorLed   = r_err;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: directed vectors plus corner sequences for lcd_write_arbiter.
module tb_lcd_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    lcd_write_arbiter_if #(.NUM_REQ(3)) bus ();
    lcd_write_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(1024), .TIMEOUT_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    logic [2:0] rv = '0, rrs = '0, rburst = '0, sec = '0, sec_rs = '0;
    logic [7:0] rd [3];
    logic [7:0] sec_d [3];
    logic       ctl_man = 1'b0, man_lock = 1'b0, ctl_lock = 1'b0, prev_wr = 1'b0;
    int         ctl_t = -1, ctl_d = 0, ctl_h = 1;
    int         n_iss, n_ack, wr_hi, n_chk, n_err;
    logic [8:0] iss [16];
    assign bus.reqValid = rv;
    assign bus.reqRs    = rrs;
    assign bus.reqBurst = rburst;
    assign bus.reqData  = {rd[2], rd[1], rd[0]};
    assign bus.busLock  = ctl_man ? man_lock : ctl_lock;
    typedef struct {
        logic [2:0]      valid, rs, burst;
        logic [7:0]      d0, d1, d2;
        int              sec_id;
        logic            s_rs;
        logic [7:0]      s_d;
        int              d, h, n_exp, wr_cyc;
        logic [3:0][8:0] exp;
    } vec_t;
    vec_t vec [4];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // One cycle of the controller model, issue monitor and requester models.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            ctl_t = -1; prev_wr = 1'b0; ctl_lock = 1'b0;
        end else begin
            if (bus.wrValid && !prev_wr) begin
                if (n_iss < 16) iss[n_iss] = {bus.addrOrData, bus.inBus};
                n_iss++;
                ctl_t = 0;
            end else if (ctl_t >= 0) ctl_t++;
            if (bus.wrValid) wr_hi++;
            prev_wr  = bus.wrValid;
            ctl_lock = ctl_t >= ctl_d && ctl_t < ctl_d + ctl_h;
            if (bus.reqAck != 0) n_ack++;
            for (int i = 0; i < 3; i++) begin
                if (bus.reqAck[i]) begin
                    if (sec[i]) begin
                        rrs[i] = sec_rs[i]; rd[i] = sec_d[i]; rburst[i] = 1'b0; sec[i] = 1'b0;
                    end else rv[i] = 1'b0;
                end
            end
        end
    endtask
    task automatic do_reset();
        rst = 1'b0; rv = '0; sec = '0; rburst = '0; ctl_man = 1'b0; man_lock = 1'b0;
        tick(); tick();
        chk("reset_outputs", {bus.wrValid, bus.addrOrData, bus.inBus, bus.reqAck, bus.errorLed}, 0);
        n_iss = 0; n_ack = 0; wr_hi = 0;
        rst = 1'b1;
    endtask
    initial begin
        int cnt;
        n_chk = 0; n_err = 0;
        vec[0] = '{valid:3'b001, rs:3'b000, burst:3'b000, d0:8'h80, d1:8'h00, d2:8'h00,
                   sec_id:-1, s_rs:1'b0, s_d:8'h00, d:2, h:5, n_exp:1, wr_cyc:3,
                   exp:{9'h000, 9'h000, 9'h000, 9'h080}};
        vec[1] = '{valid:3'b111, rs:3'b000, burst:3'b000, d0:8'hA0, d1:8'hA1, d2:8'hA2,
                   sec_id:0, s_rs:1'b1, s_d:8'hA3, d:0, h:1, n_exp:4, wr_cyc:1,
                   exp:{9'h1A3, 9'h0A2, 9'h0A1, 9'h0A0}};
        vec[2] = '{valid:3'b110, rs:3'b000, burst:3'b010, d0:8'h00, d1:8'h01, d2:8'hC2,
                   sec_id:1, s_rs:1'b1, s_d:8'h35, d:0, h:1, n_exp:3, wr_cyc:1,
                   exp:{9'h000, 9'h0C2, 9'h135, 9'h001}};
        vec[3] = '{valid:3'b101, rs:3'b001, burst:3'b000, d0:8'h5A, d1:8'h00, d2:8'hC3,
                   sec_id:-1, s_rs:1'b0, s_d:8'h00, d:3, h:2, n_exp:2, wr_cyc:4,
                   exp:{9'h000, 9'h000, 9'h0C3, 9'h15A}};
        for (int v = 0; v < 4; v++) begin
            do_reset();
            rrs = vec[v].rs; rburst = vec[v].burst;
            rd[0] = vec[v].d0; rd[1] = vec[v].d1; rd[2] = vec[v].d2;
            if (vec[v].sec_id >= 0) begin
                sec[vec[v].sec_id] = 1'b1; sec_rs[vec[v].sec_id] = vec[v].s_rs; sec_d[vec[v].sec_id] = vec[v].s_d;
            end
            ctl_d = vec[v].d; ctl_h = vec[v].h;
            rv = vec[v].valid;
            for (int c = 0; c < 400 && n_ack < vec[v].n_exp; c++) tick();
            repeat (8) tick();
            chk($sformatf("v%0d_acks", v), n_ack, vec[v].n_exp);
            chk($sformatf("v%0d_issues", v), n_iss, vec[v].n_exp);
            for (int k = 0; k < vec[v].n_exp; k++)
                chk($sformatf("v%0d_issue%0d", v, k), iss[k], vec[v].exp[k]);
            chk($sformatf("v%0d_wr_cycles", v), wr_hi, vec[v].n_exp * vec[v].wr_cyc);
            chk($sformatf("v%0d_err", v), bus.errorLed, 0);
        end
        // Timeout: controller never locks.
        do_reset();
        ctl_man = 1'b1; man_lock = 1'b0;
        rrs = 3'b000; rd[0] = 8'h11; rv = 3'b001;
        for (int c = 0; c < 50 && n_iss < 1; c++) tick();
        cnt = 0;
        while (cnt < 1100 && !bus.errorLed) begin tick(); cnt++; end
        chk("timeout_cycles", cnt, 1024);
        chk("timeout_wr", bus.wrValid, 0);
        chk("timeout_ack", bus.reqAck, 3'b001);
        ctl_man = 1'b0; ctl_d = 0; ctl_h = 1;
        rrs = 3'b100; rd[2] = 8'h22; rv = 3'b100;
        for (int c = 0; c < 100 && n_ack < 2; c++) tick();
        chk("after_timeout_issue", iss[1], 9'h122);
        chk("after_timeout_acks", n_ack, 2);
        chk("err_sticky", bus.errorLed, 1);
        // Reset during WAIT_RELEASE.
        do_reset();
        ctl_d = 0; ctl_h = 20;
        rrs = 3'b001; rd[0] = 8'h44; rd[1] = 8'h55; rv = 3'b001;
        for (int c = 0; c < 50 && n_iss < 1; c++) tick();
        repeat (4) tick();
        chk("pre_abort_bus", {bus.wrValid, bus.addrOrData, bus.inBus}, 9'h144);
        #2 rst = 1'b0;
        #1 chk("async_reset", {bus.wrValid, bus.addrOrData, bus.inBus, bus.reqAck, bus.errorLed}, 0);
        repeat (3) tick();
        chk("abort_no_ack", n_ack, 0);
        n_iss = 0; n_ack = 0; ctl_h = 1;
        rv = 3'b011;
        rst = 1'b1;
        for (int c = 0; c < 100 && n_ack < 2; c++) tick();
        chk("post_reset_first", iss[0], 9'h144);
        chk("post_reset_second", iss[1], 9'h055);
        // busLock already asserted at issue.
        do_reset();
        ctl_man = 1'b1; man_lock = 1'b1;
        rrs = 3'b001; rd[0] = 8'h66; rv = 3'b001;
        for (int c = 0; c < 50 && n_iss < 1; c++) tick();
        tick();
        chk("prelock_wr_one_cycle", bus.wrValid, 0);
        tick();
        chk("prelock_no_early_ack", bus.reqAck, 0);
        man_lock = 1'b0;
        tick();
        chk("prelock_ack", bus.reqAck, 3'b001);
        repeat (10) tick();
        chk("prelock_single_issue", n_iss, 1);
        chk("prelock_single_ack", n_ack, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Shares the single LCD write channel (addrOrData, inBus, busLock handshake into the LCD controller) between NUM_REQ requesters, e.g. init sequencer, digit updater, diagnostics.
- Round-robin grant, with optional burst hold so an address/data pair from one requester stays atomic.
- Supervises the controller handshake with a timeout that raises a sticky error LED.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, max cycles per handshake phase before an error.
- TIMEOUT_W, 10, counter width; must satisfy 2^TIMEOUT_W >= TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset; the LCD on signal.
- reqValid  in  NUM_REQ  request pending per requester; held until its reqAck.
- reqRs  in  NUM_REQ  per requester: 0 = command/address, 1 = data.
- reqData  in  8*NUM_REQ  byte per requester; requester i uses bits [8i+7:8i].
- reqBurst  in  NUM_REQ  keep the grant after this transfer.
- reqAck  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- busLock  in  1  from controller; 1 = locked/busy, 0 = unlocked.
- wrValid  out  1  write strobe to the controller.
- addrOrData  out  1  rs for the issued byte.
- inBus  out  8  byte to the controller.
- errorLed  out  1  sticky timeout flag.

Behaviour:
- Reset, asynchronous while rst=0:
  - wrValid=0, addrOrData=0, inBus=8'h00, reqAck=0, errorLed=0.
  - State=IDLE, grant=NUM_REQ-1 so requester 0 has first priority, burstHold=0, timer=0.
- IDLE:
  - If burstHold=1 and reqValid[grant]=1, re-grant the same requester.
  - Otherwise pick the first set reqValid scanning from grant+1 and wrapping modulo NUM_REQ, then clear burstHold.
  - On a pick, register grant, addrOrData<=reqRs[g], inBus<=byte g, burstHold<=reqBurst[g], wrValid<=1, timer<=0, go to WAIT_LOCK.
  - If no reqValid is set, stay in IDLE with outputs held and wrValid=0.
  - Latency: wrValid rises at the first edge after reqValid is sampled in IDLE.
- WAIT_LOCK:
  - wrValid, addrOrData and inBus are held stable.
  - When busLock=1: wrValid<=0, timer<=0, go to WAIT_RELEASE.
  - Otherwise timer increments.
- WAIT_RELEASE:
  - When busLock=0: reqAck[grant]<=1, go to ACK.
  - Otherwise timer increments.
- ACK:
  - Lasts exactly one cycle with reqAck[grant]=1, then reqAck<=0 and go to IDLE.
  - reqValid is not sampled in ACK, so a requester with registered outputs can retire or replace its request without a duplicate issue.
- Timeout:
  - In WAIT_LOCK or WAIT_RELEASE, timer==TIMEOUT_CYCLES-1 forces: errorLed<=1, wrValid<=0, burstHold<=0, go to ACK (the requester is freed).
  - errorLed clears only on reset.
- Back-to-back: the minimum period per transfer is 4 cycles (IDLE, WAIT_LOCK, WAIT_RELEASE, ACK) with an immediate controller.
- busLock already 1 at issue: completes WAIT_LOCK in one cycle. This is legal, treated as accepted.
- Simultaneous requests: exactly one grant. The others remain pending and are served in rotation, so none waits more than NUM_REQ transfers, burst holds excepted.
- Burst ends when the holder's reqValid=0 in IDLE or its reqBurst=0 on the latest grant.
- Requester drops reqValid mid-transfer: ignored; the transfer completes and is still acked.
- Reset mid-operation: immediate return to reset values. No ack is issued for the aborted transfer.
- Out-of-range grant (NUM_REQ not a power of 2): the picker treats it as NUM_REQ-1.

Decomposition:
- Shared package lcd_pkg holds:
  - State encoding: IDLE, WAIT_LOCK, WAIT_RELEASE, ACK.
  - Constants ADDR=1'b0, DATA=1'b1, LOCKED=1'b1, UNLOCKED=1'b0.
  - These are reused by the existing interface and controller blocks.
- One sub-module: lcd_rr_pick, a combinational round-robin picker.
  - Inputs: reqValid, last grant.
  - Outputs: found, index.
  - Instantiated once.

Test Plan:
1. Reset release, reqValid=3'b001, reqRs=0, data0=8'h80; controller raises busLock 2 cycles after wrValid and holds it 5 cycles -> wrValid high 3 cycles, addrOrData=0, inBus=80, reqAck[0] one pulse, errorLed=0.
2. reqValid=3'b111 held continuously, reqBurst=0 -> grant order 0,1,2,0; each inBus matches its requester's byte; no duplicate transfers.
3. Requester 1 sends rs=0, data 8'h01 with reqBurst=1, then rs=1, data 8'h35, while requester 2 is also valid -> both requester-1 bytes are issued consecutively, then requester 2.
4. busLock held 0 for 1024 cycles after issue -> errorLed=1 at cycle 1024, wrValid=0, reqAck pulses; the next request still proceeds and errorLed stays 1.
5. rst pulled low during WAIT_RELEASE -> all outputs return to reset values asynchronously with no reqAck pulse; after release, requester 0 wins first.
6. busLock already 1 when the write issues -> one-cycle WAIT_LOCK, ack after busLock falls, and no re-issue of the same byte.
